// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides operand magnitudes over 32 CALC steps, then fixes the result sign in a FIX cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             ce_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             div_by_zero_o
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state, w_next;
    logic             r_is_rem, r_q_neg, r_r_neg, r_dbz;
    logic [WIDTH-1:0] r_rem, r_q, r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_ready, r_dbz_out;

    logic             w_signed, w_zero;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_res, w_r_res;
    logic [WIDTH:0]   w_trial;

    assign w_signed = ~op_i[0];
    assign w_zero   = (divisor_i == '0);
    assign w_a_mag  = (w_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign w_b_mag  = (w_signed && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    // Remainder stays below the divisor, so its 33rd bit is always zero and is not stored.
    assign w_trial  = {r_rem, r_q[WIDTH-1]} - {1'b0, r_dvs};
    assign w_q_res  = r_q_neg ? -r_q   : r_q;
    assign w_r_res  = r_r_neg ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)
            r_state <= S_IDLE;
        else if (ce_i)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_i) w_next = w_zero ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_is_rem  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dbz     <= 1'b0;
            r_rem     <= '0;
            r_q       <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_dbz_out <= 1'b0;
        end else if (ce_i) begin
            r_ready   <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                S_IDLE: if (valid_i) begin
                    r_is_rem <= op_i[1];
                    r_cnt    <= '0;
                    r_dvs    <= w_b_mag;
                    if (w_zero) begin
                        // Preload so FIX yields all-ones quotient / raw dividend remainder.
                        r_dbz   <= 1'b1;
                        r_q_neg <= 1'b0;
                        r_r_neg <= 1'b0;
                        r_q     <= '1;
                        r_rem   <= dividend_i;
                    end else begin
                        r_dbz   <= 1'b0;
                        r_q_neg <= w_signed & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_r_neg <= w_signed & dividend_i[WIDTH-1];
                        r_q     <= w_a_mag;
                        r_rem   <= '0;
                    end
                end
                S_CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_ready   <= 1'b1;
                    r_dbz_out <= r_dbz;
                    r_result  <= r_is_rem ? w_r_res : w_q_res;
                end
                default: ;
            endcase
        end
    end

    assign result_o      = r_result;
    assign ready_o       = r_ready;
    assign div_by_zero_o = r_dbz_out;
endmodule
